// File: rtl/seg7_scan_ctrl_if.sv
// Peripheral bus bundle for the 7-segment scan controller.
// One-cycle select strobe, write/read qualifier, registered read data.
interface seg7_scan_ctrl_if #(
    parameter int ADDR_W = 3
) ();
    logic              sel;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        wdata;
    logic [7:0]        rdata;

    modport master (
        output sel,
        output we,
        output addr,
        output wdata,
        input  rdata
    );

    modport slave (
        input  sel,
        input  we,
        input  addr,
        input  wdata,
        output rdata
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode 7-segment controller with bus-mapped digit
// registers, PWM brightness, blinking and a programmable scan period.
module seg7_scan_ctrl #(
    parameter int NDIG         = 4,
    parameter int ADDR_W       = 3,
    parameter int DIV          = 50000,
    parameter int CNT_W        = 16,
    parameter int BLINK_FRAMES = 250
) (
    input  logic                 clk,
    input  logic                 rst,
    seg7_scan_ctrl_if.slave      bus,
    output logic [7:0]           segments,
    output logic [NDIG-1:0]      enable
);

    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int BF_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [ADDR_W-1:0] CTRL_A  = '1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_MAX = IDX_W'(NDIG - 1);
    localparam logic [BF_W-1:0]   BF_MAX  = BF_W'(BLINK_FRAMES - 1);
    localparam logic [CNT_W:0]    SLOT8   = (CNT_W + 1)'(DIV / 8);
    localparam logic [NDIG-1:0]   EN_RST  = ~NDIG'(1);

    logic [5:0]       dig [NDIG];
    logic [2:0]       bright;
    logic             blink_en;
    logic             disp_en;

    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic [BF_W-1:0]  bcnt;
    logic             phase;

    logic             wr;
    logic             rd;
    logic             wrap;
    logic             frame_end;
    logic [7:0]       rd_d;
    logic [5:0]       cur;
    logic [CNT_W:0]   thr;
    logic             on;
    logic [7:0]       seg_d;
    logic [NDIG-1:0]  en_d;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    assign wr        = bus.sel & bus.we;
    assign rd        = bus.sel & ~bus.we;
    assign wrap      = (cnt == CNT_MAX);
    assign frame_end = wrap && (idx == IDX_MAX);

    // Bus writes into the digit and control registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NDIG; i++) dig[i] <= '0;
            bright   <= 3'd7;
            blink_en <= 1'b0;
            disp_en  <= 1'b1;
        end else if (wr) begin
            for (int i = 0; i < NDIG; i++) begin
                if (bus.addr == ADDR_W'(i)) dig[i] <= bus.wdata[5:0];
            end
            if (bus.addr == CTRL_A) begin
                bright   <= bus.wdata[2:0];
                blink_en <= bus.wdata[3];
                disp_en  <= bus.wdata[4];
            end
        end
    end

    // Read-data mux; unmapped addresses return zero.
    always_comb begin
        rd_d = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (bus.addr == ADDR_W'(i)) rd_d = {2'b00, dig[i]};
        end
        if (bus.addr == CTRL_A) rd_d = {3'b000, disp_en, blink_en, bright};
    end

    // Read data is captured on a read strobe and held until the next one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) bus.rdata <= '0;
        else if (rd) bus.rdata <= rd_d;
    end

    // Refresh counter and scan index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= wrap ? '0 : cnt + 1'b1;
            if (wrap) idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
        end
    end

    // Blink phase toggles every BLINK_FRAMES frames while enabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bcnt  <= '0;
            phase <= 1'b0;
        end else if (!blink_en) begin
            bcnt  <= '0;
            phase <= 1'b0;
        end else if (frame_end) begin
            if (bcnt == BF_MAX) begin
                bcnt  <= '0;
                phase <= ~phase;
            end else begin
                bcnt <= bcnt + 1'b1;
            end
        end
    end

    // Gating and pattern for the digit under scan.
    always_comb begin
        cur = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (idx == IDX_W'(i)) cur = dig[i];
        end
        thr = ({{(CNT_W - 2){1'b0}}, bright} + 1'b1) * SLOT8;
        on  = disp_en && !cur[5] && !(blink_en && phase) &&
              ({1'b0, cnt} < thr);
        seg_d = on ? {~cur[4], hex7(cur[3:0])} : 8'hFF;
        en_d  = '1;
        for (int i = 0; i < NDIG; i++) begin
            en_d[i] = ~(on && (idx == IDX_W'(i)));
        end
    end

    // Registered pin drivers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            segments <= 8'hC0;
            enable   <= EN_RST;
        end else begin
            segments <= seg_d;
            enable   <= en_d;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with NDIG=4, DIV=8, BLINK_FRAMES=2.
// A small timing model tracks the expected pin pattern edge by edge.
module tb_seg7_scan_ctrl;

    localparam int NDIG   = 4;
    localparam int ADDR_W = 3;
    localparam int DIV    = 8;
    localparam int CNT_W  = 16;
    localparam int BF     = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] segments;
    logic [3:0] enable;

    always #5 clk = ~clk;

    seg7_scan_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    seg7_scan_ctrl #(
        .NDIG(NDIG),
        .ADDR_W(ADDR_W),
        .DIV(DIV),
        .CNT_W(CNT_W),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .segments(segments),
        .enable(enable)
    );

    int checks = 0;
    int errors = 0;
    int n = 0;

    logic [6:0] hex [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                             7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                             7'h46, 7'h21, 7'h06, 7'h0E};

    logic [3:0] m_val [4];
    logic       m_dot [4];
    logic       m_blank [4];
    logic [2:0] m_bright;
    logic       m_blinken;
    logic       m_disp;
    logic       m_phase;
    int         m_bcnt;
    logic [7:0] exp_seg;
    logic [3:0] exp_en;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_val[i]   = 4'h0;
            m_dot[i]   = 1'b0;
            m_blank[i] = 1'b0;
        end
        m_bright  = 3'd7;
        m_blinken = 1'b0;
        m_disp    = 1'b1;
        m_phase   = 1'b0;
        m_bcnt    = 0;
        n         = 0;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        int   c;
        int   ix;
        logic on;
        c  = n % DIV;
        ix = (n / DIV) % NDIG;
        on = m_disp && !m_blank[ix] && !(m_blinken && m_phase) &&
             (c < (int'(m_bright) + 1) * (DIV / 8));
        exp_seg = on ? {~m_dot[ix], hex[m_val[ix]]} : 8'hFF;
        exp_en  = on ? ~(4'b0001 << ix) : 4'hF;
        if (!m_blinken) begin
            m_bcnt  = 0;
            m_phase = 1'b0;
        end else if (c == DIV - 1 && ix == NDIG - 1) begin
            if (m_bcnt == BF - 1) begin
                m_bcnt  = 0;
                m_phase = ~m_phase;
            end else begin
                m_bcnt++;
            end
        end
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic tick_chk(input string tag);
        tick();
        chk({tag, " seg"}, segments, exp_seg);
        chk({tag, " en"}, {4'h0, enable}, {4'h0, exp_en});
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        bus.sel   = 1'b1;
        bus.we    = 1'b1;
        bus.addr  = a;
        bus.wdata = d;
        tick_chk("wr");
        bus.sel = 1'b0;
        bus.we  = 1'b0;
        if (a < 3'd4) begin
            m_val[a[1:0]]   = d[3:0];
            m_dot[a[1:0]]   = d[4];
            m_blank[a[1:0]] = d[5];
        end else if (a == 3'd7) begin
            m_bright  = d[2:0];
            m_blinken = d[3];
            m_disp    = d[4];
        end
    endtask

    task automatic rd(input logic [2:0] a, input logic [7:0] exp,
                      input string tag);
        bus.sel  = 1'b1;
        bus.we   = 1'b0;
        bus.addr = a;
        tick_chk("rd");
        bus.sel = 1'b0;
        chk(tag, bus.rdata, exp);
    endtask

    initial begin
        bus.sel   = 1'b0;
        bus.we    = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        model_reset();
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst seg", segments, 8'hC0);
        chk("rst en", {4'h0, enable}, 8'h0E);
        chk("rst rdata", bus.rdata, 8'h00);
        rst = 1'b1;

        for (int i = 0; i < 32; i++) tick_chk("idle");
        chk("idle last en", {4'h0, enable}, 8'h07);
        chk("idle last seg", segments, 8'hC0);
        rd(3'd7, 8'h17, "ctrl rst");

        wr(3'd1, 8'h1A);
        rd(3'd1, 8'h1A, "rb1");
        for (int i = 0; i < 40 && ((n - 1) / DIV) % NDIG != 1; i++)
            tick_chk("to d1");
        chk("d1 seg", segments, 8'h08);
        chk("d1 en", {4'h0, enable}, 8'h0D);

        wr(3'd7, 8'h11);
        for (int i = 0; i < 32; i++) tick_chk("bright");
        for (int i = 0; i < 10 && (n - 1) % DIV != 2; i++)
            tick_chk("to c2");
        chk("dim seg", segments, 8'hFF);
        chk("dim en", {4'h0, enable}, 8'h0F);

        for (int i = 0; i < 10 && n % DIV != DIV - 1; i++)
            tick_chk("to wrap");
        wr(3'd0, 8'h15);
        for (int i = 0; i < 16; i++) tick_chk("wrapwr");

        wr(3'd2, 8'h20);
        for (int i = 0; i < 32; i++) tick_chk("blank");
        wr(3'd7, 8'h07);
        for (int i = 0; i < 16; i++) tick_chk("off");
        chk("off en", {4'h0, enable}, 8'h0F);
        chk("off seg", segments, 8'hFF);

        wr(3'd7, 8'h1F);
        for (int i = 0; i < 160; i++) tick_chk("blink");
        for (int i = 0; i < 200 && !m_phase; i++) tick_chk("to dark");
        for (int i = 0; i < 3; i++) tick_chk("dark");
        chk("dark en", {4'h0, enable}, 8'h0F);
        chk("dark seg", segments, 8'hFF);
        wr(3'd7, 8'h17);
        for (int i = 0; i < 16; i++) tick_chk("unblink");

        for (int i = 0; i < 40 && !(n % DIV == 3 && (n / DIV) % NDIG == 3);
             i++)
            tick_chk("to d3");
        #3 rst = 1'b0;
        #1;
        chk("async seg", segments, 8'hC0);
        chk("async en", {4'h0, enable}, 8'h0E);
        chk("async rdata", bus.rdata, 8'h00);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        rd(3'd7, 8'h17, "ctrl post");
        rd(3'd1, 8'h00, "d1 post");
        rd(3'd2, 8'h00, "d2 post");
        wr(3'd4, 8'hFF);
        wr(3'd5, 8'hFF);
        wr(3'd6, 8'hFF);
        rd(3'd4, 8'h00, "a4");
        rd(3'd5, 8'h00, "a5");
        rd(3'd6, 8'h00, "a6");
        rd(3'd0, 8'h00, "d0 post");
        for (int i = 0; i < 16; i++) tick_chk("post");

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
